// File: rtl/ber_monitor.sv
// ber_monitor: bit-error-rate measurement over a fixed window of word pairs.
// Compares the clean transmitted word with the received word through a
// 3-stage pipeline (xor, popcount, accumulate) and reports totals on done.
//
// Ports:
//   clk, reset      rising-edge clock, async active-high reset
//   start, abort    begin a measurement / cancel back to idle
//   in_valid        tx_word/rx_word pair valid this cycle
//   tx_word,rx_word reference and received words
//   cmp_mask        (BER_MASK_EN only) 1 = bit position is compared
//   busy            high while running or draining
//   done            one-cycle pulse, results valid
//   err_bits        saturating count of differing bits
//   err_words       saturating count of words with any differing bit
//   max_word_err    largest per-word bit-error count in the window
//   sat             sticky saturation flag, cleared by start
//
// Optional feature macro: BER_MASK_EN (adds the cmp_mask input).

module ber_monitor #(
    parameter int WORD_W       = 32,
    parameter int WINDOW_WORDS = 1024,
    parameter int CNT_W        = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         in_valid,
    input  logic [WORD_W-1:0]            tx_word,
    input  logic [WORD_W-1:0]            rx_word,
`ifdef BER_MASK_EN
    input  logic [WORD_W-1:0]            cmp_mask,
`endif
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             err_bits,
    output logic [CNT_W-1:0]             err_words,
    output logic [$clog2(WORD_W+1)-1:0]  max_word_err,
    output logic                         sat
);

    localparam int MW  = $clog2(WORD_W + 1);
    localparam int WCW = $clog2(WINDOW_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_drain;
    logic [WCW-1:0]    r_wcnt;

    logic              r_v1;
    logic [WORD_W-1:0] r_diff;
    logic              r_v2;
    logic [MW-1:0]     r_pc;

    logic [CNT_W-1:0]  r_err_bits;
    logic [CNT_W-1:0]  r_err_words;
    logic [MW-1:0]     r_max;
    logic              r_sat;

    logic              w_accept;
    logic              w_last;
    logic              w_clear;
    logic [WORD_W-1:0] w_diff;
    logic [MW-1:0]     w_pc;
    logic [CNT_W:0]    w_bsum;
    logic              w_bovf;
    logic              w_wovf;

    assign w_accept = (r_state == S_RUN) && in_valid && !abort;
    assign w_last   = w_accept && (r_wcnt == WCW'(WINDOW_WORDS - 1));
    assign w_clear  = (r_state == S_IDLE) && start && !abort;

`ifdef BER_MASK_EN
    assign w_diff = (tx_word ^ rx_word) & cmp_mask;
`else
    assign w_diff = tx_word ^ rx_word;
`endif

    always_comb begin
        w_pc = '0;
        for (int i = 0; i < WORD_W; i++) begin
            w_pc = w_pc + MW'(r_diff[i]);
        end
    end

    // One extra bit on the sum exposes overflow for saturation.
    assign w_bsum = {1'b0, r_err_bits} + (CNT_W+1)'(r_pc);
    assign w_bovf = w_bsum[CNT_W];
    assign w_wovf = (r_pc != '0) && (&r_err_words);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DRAIN;
            S_DRAIN: if (r_drain) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_drain <= 1'b0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_next;
            // r_drain marks the second drain cycle.
            r_drain <= (r_state == S_DRAIN) && !abort && !r_drain;
            if (w_clear) begin
                r_wcnt <= '0;
            end else if (w_accept) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1   <= 1'b0;
            r_diff <= '0;
            r_v2   <= 1'b0;
            r_pc   <= '0;
        end else begin
            r_v1   <= w_accept;
            r_diff <= w_diff;
            r_v2   <= r_v1 && !abort;
            r_pc   <= w_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_bits  <= '0;
            r_err_words <= '0;
            r_max       <= '0;
            r_sat       <= 1'b0;
        end else if (w_clear) begin
            r_err_bits  <= '0;
            r_err_words <= '0;
            r_max       <= '0;
            r_sat       <= 1'b0;
        end else if (r_v2 && !abort) begin
            r_err_bits <= w_bovf ? '1 : w_bsum[CNT_W-1:0];
            if ((r_pc != '0) && !w_wovf) begin
                r_err_words <= r_err_words + 1'b1;
            end
            if (r_pc > r_max) begin
                r_max <= r_pc;
            end
            r_sat <= r_sat | w_bovf | w_wovf;
        end
    end

    assign busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done         = (r_state == S_DONE);
    assign err_bits     = r_err_bits;
    assign err_words    = r_err_words;
    assign max_word_err = r_max;
    assign sat          = r_sat;

endmodule

// File: tb/tb_ber_monitor.sv
// tb_ber_monitor: directed bench for ber_monitor with a results scoreboard.
// Two instances share stimulus: CNT_W=24 and CNT_W=6 (saturation).

module tb_ber_monitor;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic [31:0] tx_word;
    logic [31:0] rx_word;
    logic [31:0] msk;

    logic        busy_a, done_a, sat_a;
    logic [23:0] bits_a, words_a;
    logic [5:0]  max_a;
    logic        busy_b, done_b, sat_b;
    logic [5:0]  bits_b, words_b;
    logic [5:0]  max_b;

    int n_err;
    int n_chk;

    typedef struct {
        logic [23:0] bits_a;
        logic [23:0] words_a;
        logic        sat_a;
        logic [5:0]  bits_b;
        logic [5:0]  words_b;
        logic        sat_b;
        logic [5:0]  mx;
    } exp_t;

    exp_t sb[$];

    logic [31:0] tx_arr[4];
    logic [31:0] df_arr[4];
    int          gap_arr[4];

    ber_monitor #(.WORD_W(32), .WINDOW_WORDS(4), .CNT_W(24)) u_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_valid(in_valid), .tx_word(tx_word), .rx_word(rx_word),
`ifdef BER_MASK_EN
        .cmp_mask(msk),
`endif
        .busy(busy_a), .done(done_a), .err_bits(bits_a),
        .err_words(words_a), .max_word_err(max_a), .sat(sat_a)
    );

    ber_monitor #(.WORD_W(32), .WINDOW_WORDS(4), .CNT_W(6)) u_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_valid(in_valid), .tx_word(tx_word), .rx_word(rx_word),
`ifdef BER_MASK_EN
        .cmp_mask(msk),
`endif
        .busy(busy_b), .done(done_b), .err_bits(bits_b),
        .err_words(words_b), .max_word_err(max_b), .sat(sat_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_window();
        exp_t e;
        int   tb;
        int   tw;
        int   mx;
        int   pc;
        int   lat;
        tb = 0;
        tw = 0;
        mx = 0;
        for (int i = 0; i < 4; i++) begin
            pc = $countones(df_arr[i] & msk);
            tb += pc;
            if (pc != 0) tw++;
            if (pc > mx) mx = pc;
        end
        e.bits_a  = 24'(tb);
        e.words_a = 24'(tw);
        e.sat_a   = 1'b0;
        e.bits_b  = (tb > 63) ? 6'd63 : 6'(tb);
        e.words_b = (tw > 63) ? 6'd63 : 6'(tw);
        e.sat_b   = (tb > 63) || (tw > 63);
        e.mx      = 6'(mx);
        sb.push_back(e);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start", 32'(busy_a), 32'd1);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap_arr[i]; g++) begin
                tick();
                chk("busy_gap", 32'(busy_a), 32'd1);
            end
            in_valid = 1'b1;
            tx_word  = tx_arr[i];
            rx_word  = tx_arr[i] ^ df_arr[i];
            tick();
            in_valid = 1'b0;
            chk("busy_acc", 32'(busy_a), 32'd1);
        end
        lat = 0;
        while (done_a !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        chk("done_lat", 32'(lat), 32'd2);
        chk("done_b", 32'(done_b), 32'd1);
        e = sb.pop_front();
        chk("bits_a", 32'(bits_a), 32'(e.bits_a));
        chk("words_a", 32'(words_a), 32'(e.words_a));
        chk("max_a", 32'(max_a), 32'(e.mx));
        chk("sat_a", 32'(sat_a), 32'(e.sat_a));
        chk("bits_b", 32'(bits_b), 32'(e.bits_b));
        chk("words_b", 32'(words_b), 32'(e.words_b));
        chk("max_b", 32'(max_b), 32'(e.mx));
        chk("sat_b", 32'(sat_b), 32'(e.sat_b));
        tick();
        chk("done_pulse", 32'(done_a), 32'd0);
        chk("busy_idle", 32'(busy_a), 32'd0);
        tick();
        chk("bits_hold", 32'(bits_a), 32'(e.bits_a));
    endtask

    initial begin
        int dcnt;
        n_err    = 0;
        n_chk    = 0;
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        tx_word  = '0;
        rx_word  = '0;
        msk      = 32'hFFFF_FFFF;
        tick();
        tick();
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_bits", 32'(bits_a), 32'd0);
        chk("rst_words", 32'(words_a), 32'd0);
        chk("rst_max", 32'(max_a), 32'd0);
        chk("rst_sat", 32'(sat_b), 32'd0);
        reset = 1'b0;
        tick();

        // clean channel
        for (int i = 0; i < 4; i++) begin
            tx_arr[i]  = 32'hA5A5_A5A5;
            df_arr[i]  = 32'h0;
            gap_arr[i] = 0;
        end
        do_window();

        // 4 errors per word with gaps
        tx_arr = '{32'h1234_5678, 32'h0, 32'hDEAD_BEEF, 32'h7};
        for (int i = 0; i < 4; i++) df_arr[i] = 32'hF;
        gap_arr = '{0, 0, 2, 1};
        do_window();

        // mixed diffs incl. all-ones word
        tx_arr  = '{32'h1, 32'h2, 32'h3, 32'h4};
        df_arr  = '{32'h1, 32'h0, 32'hFFFF_FFFF, 32'h3};
        gap_arr = '{1, 0, 0, 0};
        do_window();

        // inverted words: saturates the CNT_W=6 instance
        tx_arr  = '{32'h0F0F_0F0F, 32'h5555_AAAA, 32'h0, 32'hFFFF_0000};
        for (int i = 0; i < 4; i++) df_arr[i] = 32'hFFFF_FFFF;
        gap_arr = '{0, 0, 0, 0};
        do_window();

        // next start clears sat; then abort after 2 pairs
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clr_sat", 32'(sat_b), 32'd0);
        chk("clr_bits", 32'(bits_a), 32'd0);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            tx_word  = 32'h0;
            rx_word  = 32'h1;
            tick();
        end
        in_valid = 1'b0;
        abort    = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy_a), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done_a === 1'b1) dcnt++;
        end
        chk("abort_nodone", 32'(dcnt), 32'd0);

        // async reset mid-window
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            tx_word  = 32'h0;
            rx_word  = 32'hF;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_bits", 32'(bits_a), 32'd8);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_bits", 32'(bits_a), 32'd0);
        chk("arst_words", 32'(words_a), 32'd0);
        chk("arst_busy", 32'(busy_a), 32'd0);
        chk("arst_max", 32'(max_a), 32'd0);
        #1;
        reset = 1'b0;
        tick();
        tx_arr  = '{32'h8000_0000, 32'h1, 32'h2, 32'h3};
        df_arr  = '{32'h8000_0001, 32'h0, 32'h7, 32'h0};
        gap_arr = '{0, 1, 0, 0};
        do_window();

`ifdef BER_MASK_EN
        msk = 32'hFFFF_FC00;
        tx_arr  = '{32'h0, 32'h1111_1111, 32'h2222_2222, 32'h3};
        for (int i = 0; i < 4; i++) df_arr[i] = 32'h0000_03FF;
        gap_arr = '{0, 0, 0, 0};
        do_window();
        for (int i = 0; i < 4; i++) df_arr[i] = 32'h0000_0C00;
        do_window();
        msk = 32'hFFFF_FFFF;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
